pitch_glide_control: RTL and testbench

PITCH_GLIDE_CONTROL -- requirements
Module: pitch_glide_control

---
 rtl/pitch_glide_control_pkg.sv | 29 ++
 rtl/pitch_glide_control_glide_step.sv | 37 +++
 rtl/pitch_glide_control.sv | 199 +++++++++++++++++++
 tb/tb_pitch_glide_control.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_glide_control_pkg.sv
// ---------------------------------------------------------------------------
// pitch_glide_pkg
// Shared definitions for the pitch glide block: glide mode encoding, the
// per-oscillator register map and the glide-rate to shift decode.
// Register map: osc o owns glide_rate at RATE_ADR_OFS + o*OSC_ADR_STRIDE and
// glide_mode at MODE_ADR_OFS + o*OSC_ADR_STRIDE.
// ---------------------------------------------------------------------------
package pitch_glide_pkg;

    // Mode 3 is not a distinct behaviour; it acts like "always".
    typedef enum logic [1:0] {
        GLIDE_OFF        = 2'd0,
        GLIDE_ALWAYS     = 2'd1,
        GLIDE_LEGATO     = 2'd2,
        GLIDE_ALWAYS_ALT = 2'd3
    } glide_mode_t;

    localparam logic [6:0] RATE_ADR_OFS   = 7'd12;
    localparam logic [6:0] MODE_ADR_OFS   = 7'd13;
    localparam logic [6:0] OSC_ADR_STRIDE = 7'd16;
    localparam int         ADR_OSC_LSB    = $clog2(OSC_ADR_STRIDE);

    // Upper four rate bits pick how far the remaining distance is shifted
    // down each visit: 1 (fast) through 16 (very slow).
    function automatic logic [4:0] shiftDecode(input logic [6:0] rate);
        return 5'd1 + {1'b0, rate[6:3]};
    endfunction

endpackage

// File: rtl/pitch_glide_control_glide_step.sv
// ---------------------------------------------------------------------------
// glide_step
// One glide step: moves i_cur towards i_target by (target-cur) >>> i_shift,
// with a minimum step of one LSB so the glide always lands on the target.
// Ports:
//   i_cur     current pitch increment
//   i_target  target pitch increment
//   i_shift   right-shift amount (1..16)
//   o_curNew  next pitch increment
// ---------------------------------------------------------------------------
module glide_step #(
    parameter int PW = 24
) (
    input  logic [PW-1:0] i_cur,
    input  logic [PW-1:0] i_target,
    input  logic [4:0]    i_shift,
    output logic [PW-1:0] o_curNew
);

    logic signed [PW:0] w_diff;
    logic signed [PW:0] w_shifted;
    logic signed [PW:0] w_step;

    // Arithmetic shift floors towards minus infinity, so negative distances
    // never round to zero; only small positive distances need the +1 floor.
    // Since |step| <= |diff| the result can never overshoot the target.
    always_comb begin
        w_diff    = $signed({1'b0, i_target}) - $signed({1'b0, i_cur});
        w_shifted = w_diff >>> i_shift;
        w_step    = w_shifted;
        if ((w_shifted == '0) && (w_diff != '0)) begin
            w_step = w_diff[PW] ? '1 : (PW+1)'(1);
        end
        o_curNew = i_cur + w_step[PW-1:0];
    end

endmodule

// File: rtl/pitch_glide_control.sv
// ---------------------------------------------------------------------------
// pitch_glide_control
// Per-slot portamento for a VOICES x V_OSC oscillator bank. Each presented
// slot is glided from its stored pitch towards target_pitch over a two-stage
// pipeline (S1 read, S2 compute/write-back), result two cycles later.
// Ports:
//   sCLK_XVXOSC / reset_data   clock, async active-high reset
//   slot_valid, slot_idx, target_pitch   slot stream ({voice,osc} index)
//   note_on_stb, note_voice, note_legato note-on events (may force snap)
//   glide_sel, write, read, adr, synth_data_in, data_out   register port
//   osc_pitch_val, osc_pitch_valid       glided pitch output
// Build option: define PITCH_GLIDE_READBACK_EN to enable register readback
// on data_out; otherwise data_out is tied to zero.
// ---------------------------------------------------------------------------
module pitch_glide_control
    import pitch_glide_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int PW      = 24
) (
    input  logic                       sCLK_XVXOSC,
    input  logic                       reset_data,
    input  logic                       slot_valid,
    input  logic [V_WIDTH+O_WIDTH-1:0] slot_idx,
    input  logic [PW-1:0]              target_pitch,
    input  logic                       note_on_stb,
    input  logic [V_WIDTH-1:0]         note_voice,
    input  logic                       note_legato,
    input  logic                       glide_sel,
    input  logic                       write,
    input  logic                       read,
    input  logic [6:0]                 adr,
    input  logic [7:0]                 synth_data_in,
    output logic [7:0]                 data_out,
    output logic [PW-1:0]              osc_pitch_val,
    output logic                       osc_pitch_valid
);

    localparam int IW    = V_WIDTH + O_WIDTH;
    localparam int SLOTS = VOICES * V_OSC;

    logic [6:0]        r_glideRate [V_OSC];
    glide_mode_t       r_glideMode [V_OSC];
    logic [PW-1:0]     r_curMem    [SLOTS];
    logic [PW-1:0]     r_memCur;
    logic [SLOTS-1:0]  r_snap;
    logic [SLOTS-1:0]  r_curInit;

    logic              r_s1Valid;
    logic [IW-1:0]     r_s1Idx;
    logic [PW-1:0]     r_s1Target;
    logic              r_s1Fwd;
    logic [PW-1:0]     r_s1FwdCur;
    logic              r_s1Snap;
    logic              r_s1Init;

    logic [V_OSC-1:0]  w_noteSet;
    logic [SLOTS-1:0]  w_slotSet;
    logic [SLOTS-1:0]  w_s2Mask;
    logic              w_noteHitS1;
    logic              w_noteHitS2;
    logic [O_WIDTH-1:0] w_s2Osc;
    logic [4:0]        w_shift;
    logic [PW-1:0]     w_s2Cur;
    logic [PW-1:0]     w_stepCur;
    logic              w_s2Snap;
    logic [PW-1:0]     w_s2Result;
    logic              w_fwd;
    logic [O_WIDTH-1:0] w_adrOsc;
    logic              w_adrIsRate;
    logic              w_adrIsMode;
    logic              w_unusedBits;

    assign w_unusedBits = ^{synth_data_in[7], read};

    // A note-on forces a snap on the oscillators whose mode is off, or legato
    // when no other key was held. Modes 1 and 3 keep gliding.
    for (genvar o = 0; o < V_OSC; o++) begin : g_noteOsc
        assign w_noteSet[o] = note_on_stb &&
                              ((r_glideMode[o] == GLIDE_OFF) ||
                               ((r_glideMode[o] == GLIDE_LEGATO) && !note_legato));
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_noteSlot
        assign w_slotSet[s] = w_noteSet[s % V_OSC] && (note_voice == V_WIDTH'(s / V_OSC));
    end

    // Register decode: the stride is a power of two, so the osc number sits
    // directly in the address bits above the in-block offset.
    always_comb begin
        w_adrOsc    = adr[ADR_OSC_LSB +: O_WIDTH];
        w_adrIsRate = ((adr >> (ADR_OSC_LSB + O_WIDTH)) == '0) &&
                      (adr[ADR_OSC_LSB-1:0] == RATE_ADR_OFS[ADR_OSC_LSB-1:0]);
        w_adrIsMode = ((adr >> (ADR_OSC_LSB + O_WIDTH)) == '0) &&
                      (adr[ADR_OSC_LSB-1:0] == MODE_ADR_OFS[ADR_OSC_LSB-1:0]);
    end

    // S2 decision logic. A note-on landing in the same cycle as either stage
    // wins, so the in-flight access snaps instead of gliding. Rate zero means
    // no glide at all. A slot never written since reset reads as zero.
    // Back-to-back visits to one slot take the S2 result directly rather than
    // the RAM, which has not been written yet at that point.
    always_comb begin
        w_s2Osc      = r_s1Idx[O_WIDTH-1:0];
        w_shift      = shiftDecode(r_glideRate[w_s2Osc]);
        w_noteHitS1  = w_noteSet[slot_idx[O_WIDTH-1:0]] && (slot_idx[IW-1:O_WIDTH] == note_voice);
        w_noteHitS2  = w_noteSet[w_s2Osc] && (r_s1Idx[IW-1:O_WIDTH] == note_voice);
        w_s2Cur      = r_s1Fwd ? r_s1FwdCur : (r_s1Init ? r_memCur : '0);
        w_s2Snap     = r_s1Snap || w_noteHitS2 || (r_glideRate[w_s2Osc] == '0);
        w_s2Result   = w_s2Snap ? r_s1Target : w_stepCur;
        w_fwd        = slot_valid && r_s1Valid && (slot_idx == r_s1Idx);
        w_s2Mask     = r_s1Valid ? (SLOTS'(1) << r_s1Idx) : '0;
    end

    glide_step #(
        .PW       (PW)
    ) u_glideStep (
        .i_cur    (w_s2Cur),
        .i_target (r_s1Target),
        .i_shift  (w_shift),
        .o_curNew (w_stepCur)
    );

    // Pitch storage: one read port feeding S1, one write port from S2.
    // No reset here; r_curInit masks stale contents after reset instead.
    always_ff @(posedge sCLK_XVXOSC) begin
        if (r_s1Valid) begin
            r_curMem[r_s1Idx] <= w_s2Result;
        end
        r_memCur <= r_curMem[slot_idx];
    end

    // Pipeline, snap flags and register file. The S2 clear is applied after
    // the note-on set: a note-on that hit the S2 access has already been
    // honoured by that access, so the flag is consumed.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_data) begin
        if (reset_data) begin
            r_s1Valid       <= 1'b0;
            r_s1Idx         <= '0;
            r_s1Target      <= '0;
            r_s1Fwd         <= 1'b0;
            r_s1FwdCur      <= '0;
            r_s1Snap        <= 1'b1;
            r_s1Init        <= 1'b0;
            osc_pitch_valid <= 1'b0;
            osc_pitch_val   <= '0;
            r_snap          <= '1;
            r_curInit       <= '0;
            r_glideRate     <= '{default: '0};
            r_glideMode     <= '{default: GLIDE_OFF};
        end else begin
            r_s1Valid <= slot_valid;
            if (slot_valid) begin
                r_s1Idx    <= slot_idx;
                r_s1Target <= target_pitch;
                r_s1Fwd    <= w_fwd;
                r_s1FwdCur <= w_s2Result;
                r_s1Snap   <= (w_fwd ? 1'b0 : r_snap[slot_idx]) || w_noteHitS1;
                r_s1Init   <= r_curInit[slot_idx];
            end
            osc_pitch_valid <= r_s1Valid;
            if (r_s1Valid) begin
                osc_pitch_val <= w_s2Result;
            end
            r_snap    <= (r_snap | w_slotSet) & ~w_s2Mask;
            r_curInit <= r_curInit | w_s2Mask;
            if (glide_sel && write) begin
                if (w_adrIsRate) begin
                    r_glideRate[w_adrOsc] <= synth_data_in[6:0];
                end
                if (w_adrIsMode) begin
                    r_glideMode[w_adrOsc] <= glide_mode_t'(synth_data_in[1:0]);
                end
            end
        end
    end

`ifdef PITCH_GLIDE_READBACK_EN
    // Readback returns the addressed register one cycle after the strobe;
    // reads of unmapped addresses leave the previous value in place.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_data) begin
        if (reset_data) begin
            data_out <= '0;
        end else if (glide_sel && read) begin
            if (w_adrIsRate) begin
                data_out <= {1'b0, r_glideRate[w_adrOsc]};
            end else if (w_adrIsMode) begin
                data_out <= {6'b0, r_glideMode[w_adrOsc]};
            end
        end
    end
`else
    assign data_out = '0;
`endif

endmodule

// File: tb/tb_pitch_glide_control.sv
// ---------------------------------------------------------------------------
// tb_pitch_glide_control
// Directed bench for pitch_glide_control: a table of single-slot visits with
// hand-computed glide results, plus sequences for legato note-ons, same-slot
// back-to-back forwarding, note-on coincidence, reset mid-flight and
// register readback (PITCH_GLIDE_READBACK_EN selects the readback values).
// ---------------------------------------------------------------------------
module tb_pitch_glide_control;

    logic        clk;
    logic        rst;
    logic        slot_valid;
    logic [4:0]  slot_idx;
    logic [23:0] target_pitch;
    logic        note_on_stb;
    logic [2:0]  note_voice;
    logic        note_legato;
    logic        glide_sel;
    logic        write;
    logic        read;
    logic [6:0]  adr;
    logic [7:0]  synth_data_in;
    logic [7:0]  data_out;
    logic [23:0] osc_pitch_val;
    logic        osc_pitch_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [23:0] target;
        logic [23:0] expVal;
    } vec_t;

    vec_t vecs[16];

    pitch_glide_control dut (
        .sCLK_XVXOSC     (clk),
        .reset_data      (rst),
        .slot_valid      (slot_valid),
        .slot_idx        (slot_idx),
        .target_pitch    (target_pitch),
        .note_on_stb     (note_on_stb),
        .note_voice      (note_voice),
        .note_legato     (note_legato),
        .glide_sel       (glide_sel),
        .write           (write),
        .read            (read),
        .adr             (adr),
        .synth_data_in   (synth_data_in),
        .data_out        (data_out),
        .osc_pitch_val   (osc_pitch_val),
        .osc_pitch_valid (osc_pitch_valid)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] idx, input logic [23:0] target);
        @(negedge clk);
        slot_valid   = 1'b1;
        slot_idx     = idx;
        target_pitch = target;
    endtask

    task automatic visitSlot(input logic [4:0] idx, input logic [23:0] target,
                             input logic [23:0] expVal, input string tag);
        applyStimulus(idx, target);
        @(negedge clk);
        slot_valid = 1'b0;
        checkOutput({tag, " early"}, {31'b0, osc_pitch_valid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, " valid"}, {31'b0, osc_pitch_valid}, 32'd1);
        checkOutput({tag, " val"}, {8'b0, osc_pitch_val}, {8'b0, expVal});
    endtask

    task automatic writeReg(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        glide_sel     = 1'b1;
        write         = 1'b1;
        adr           = a;
        synth_data_in = d;
        @(negedge clk);
        glide_sel = 1'b0;
        write     = 1'b0;
    endtask

    task automatic readReg(input logic [6:0] a, input logic [7:0] expData, input string tag);
        @(negedge clk);
        glide_sel = 1'b1;
        read      = 1'b1;
        adr       = a;
        @(negedge clk);
        glide_sel = 1'b0;
        read      = 1'b0;
        checkOutput(tag, {24'b0, data_out}, {24'b0, expData});
    endtask

    task automatic noteOn(input logic [2:0] voice, input logic legato);
        @(negedge clk);
        note_on_stb = 1'b1;
        note_voice  = voice;
        note_legato = legato;
        @(negedge clk);
        note_on_stb = 1'b0;
    endtask

    logic [7:0] rbExpect;

    initial begin
        logic [23:0] fwdExp [3];
        fwdExp[0] = 24'd4;
        fwdExp[1] = 24'd6;
        fwdExp[2] = 24'd7;

`ifdef PITCH_GLIDE_READBACK_EN
        rbExpect = 8'h2A;
`else
        rbExpect = 8'h00;
`endif

        // slots: 0 = v0/o0, 1 = v0/o1, 2 = v0/o2, 3 = v0/o3, 20 = v5/o0
        vecs[0]  = '{5'd0,  24'h100000, 24'h100000};
        vecs[1]  = '{5'd0,  24'h200000, 24'h140000};
        vecs[2]  = '{5'd0,  24'h200000, 24'h170000};
        vecs[3]  = '{5'd0,  24'h200000, 24'h194000};
        vecs[4]  = '{5'd1,  24'h001000, 24'h001000};
        vecs[5]  = '{5'd1,  24'h001001, 24'h001001};
        vecs[6]  = '{5'd1,  24'h000FFE, 24'h001000};
        vecs[7]  = '{5'd1,  24'h000FFE, 24'h000FFF};
        vecs[8]  = '{5'd1,  24'h000FFE, 24'h000FFE};
        vecs[9]  = '{5'd1,  24'h000FFE, 24'h000FFE};
        vecs[10] = '{5'd2,  24'h000005, 24'h000005};
        vecs[11] = '{5'd2,  24'h000100, 24'h000100};
        vecs[12] = '{5'd3,  24'h000100, 24'h000100};
        vecs[13] = '{5'd3,  24'h000200, 24'h000140};
        vecs[14] = '{5'd20, 24'h123456, 24'h123456};
        vecs[15] = '{5'd0,  24'h200000, 24'h1AF000};

        rst           = 1'b1;
        slot_valid    = 1'b0;
        slot_idx      = '0;
        target_pitch  = '0;
        note_on_stb   = 1'b0;
        note_voice    = '0;
        note_legato   = 1'b0;
        glide_sel     = 1'b0;
        write         = 1'b0;
        read          = 1'b0;
        adr           = '0;
        synth_data_in = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset valid", {31'b0, osc_pitch_valid}, 32'd0);
        checkOutput("reset val", {8'b0, osc_pitch_val}, 32'd0);
        checkOutput("reset data_out", {24'b0, data_out}, 32'd0);
        rst = 1'b0;

        // Readback of osc 1 rate, then an unmapped read that must hold.
        writeReg(7'd28, 8'h2A);
        readReg(7'd28, rbExpect, "readback adr28");
        readReg(7'd5, rbExpect, "readback unmapped hold");

        writeReg(7'd12, 8'h08);
        writeReg(7'd13, 8'h01);
        writeReg(7'd28, 8'h78);
        writeReg(7'd29, 8'h01);
        writeReg(7'd44, 8'h00);
        writeReg(7'd45, 8'h01);
        writeReg(7'd60, 8'h08);
        writeReg(7'd61, 8'h02);

        for (int i = 0; i < 16; i++) begin
            visitSlot(vecs[i].idx, vecs[i].target, vecs[i].expVal, $sformatf("vec%0d", i));
        end

        // Legato note-on keeps gliding; a fresh note-on snaps osc 3 only.
        noteOn(3'd0, 1'b1);
        visitSlot(5'd3, 24'h000200, 24'h000170, "legato held");
        noteOn(3'd0, 1'b0);
        visitSlot(5'd3, 24'h000200, 24'h000200, "legato fresh snap");
        visitSlot(5'd0, 24'h200000, 24'h1C3400, "mode1 ignores note");

        // Same slot on three consecutive cycles at shift 1 from cur = 0.
        writeReg(7'd44, 8'h01);
        visitSlot(5'd6, 24'h000000, 24'h000000, "fwd prime");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checkOutput($sformatf("fwd%0d valid", k - 2), {31'b0, osc_pitch_valid}, 32'd1);
                checkOutput($sformatf("fwd%0d val", k - 2), {8'b0, osc_pitch_val}, {8'b0, fwdExp[k - 2]});
            end
            if (k < 3) begin
                slot_valid   = 1'b1;
                slot_idx     = 5'd6;
                target_pitch = 24'd8;
            end else begin
                slot_valid = 1'b0;
            end
        end

        // Note-on arriving in the same cycle as the slot forces a snap.
        visitSlot(5'd7, 24'h000100, 24'h000100, "coinc prime");
        @(negedge clk);
        slot_valid   = 1'b1;
        slot_idx     = 5'd7;
        target_pitch = 24'h000200;
        note_on_stb  = 1'b1;
        note_voice   = 3'd1;
        note_legato  = 1'b0;
        @(negedge clk);
        slot_valid  = 1'b0;
        note_on_stb = 1'b0;
        @(negedge clk);
        checkOutput("coinc valid", {31'b0, osc_pitch_valid}, 32'd1);
        checkOutput("coinc val", {8'b0, osc_pitch_val}, 32'h000200);

        // Reset while a slot is in flight: nothing emerges afterwards.
        applyStimulus(5'd0, 24'h200000);
        @(negedge clk);
        slot_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset valid", {31'b0, osc_pitch_valid}, 32'd0);
        checkOutput("midreset val", {8'b0, osc_pitch_val}, 32'd0);
        checkOutput("midreset data_out", {24'b0, data_out}, 32'd0);
        @(negedge clk);
        checkOutput("midreset valid later", {31'b0, osc_pitch_valid}, 32'd0);
        visitSlot(5'd0, 24'h000055, 24'h000055, "post reset snap");
        writeReg(7'd44, 8'h01);
        visitSlot(5'd6, 24'h000008, 24'h000008, "post reset slot6 snap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
